// File: rtl/mips_rf_pkg.sv
// Shared defaults and address helpers for the MIPS register file with busy scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_rf_pkg;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = $clog2(RF_DEPTH);

    typedef logic [RF_AW-1:0] rf_addr_t;

    // Register hard-wired to zero when the zero-register option is enabled.
    localparam rf_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/rf_write_decoder.sv
// Decodes (en, addr) into a one-hot DEPTH-bit vector; addresses >= DEPTH give all zeros.
// Latency: combinational.
// Backpressure: none.
// Ports: en (decode enable), addr (AW-bit index), onehot (DEPTH-bit select vector).
module rf_write_decoder
    import mips_rf_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             en,
    input  logic [AW-1:0]    addr,
    output logic [DEPTH-1:0] onehot
);

    // Only indices 0..DEPTH-1 can match, so out-of-range addresses fall out naturally.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (en && (addr == AW'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_reg_file_sb.sv
// MIPS register file (2 combinational read ports, 1 write port) with per-register busy scoreboard.
// Latency: reads zero-cycle; writes and allocs take effect at the next posedge clk.
// Backpressure: none; rd_ready_a/rd_ready_b report whether the addressed operand is still pending.
// Ports: clk, reset (sync, active-low); reg_write/wr_addr/wr_data write-back; alloc_valid/alloc_addr
//        issue-time destination marking; rd_addr_x -> rd_data_x/rd_ready_x; busy_vec raw scoreboard.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module mips_reg_file_sb
    import mips_rf_pkg::*;
#(
    parameter int               WIDTH      = RF_WIDTH,
    parameter int               DEPTH      = RF_DEPTH,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    parameter int               ZERO_REG   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reg_write,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     alloc_valid,
    input  logic [$clog2(DEPTH)-1:0] alloc_addr,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_a,
    output logic [WIDTH-1:0]         rd_data_a,
    output logic                     rd_ready_a,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_b,
    output logic [WIDTH-1:0]         rd_data_b,
    output logic                     rd_ready_b,
    output logic [DEPTH-1:0]         busy_vec
);

    localparam int AW = $clog2(DEPTH);

    // Registers that can be written, allocated or read back; clears bit 0 when it is the zero register.
    localparam logic [DEPTH-1:0] LIVE_MASK = (ZERO_REG != 0)
        ? ~(DEPTH'(1) << AW'(ZERO_ADDR))
        : {DEPTH{1'b1}};

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] we_raw;
    logic [DEPTH-1:0] al_raw;
    logic [DEPTH-1:0] we_vec;
    logic [DEPTH-1:0] al_vec;

    rf_write_decoder #(.DEPTH(DEPTH), .AW(AW)) u_we_dec (
        .en     (reg_write),
        .addr   (wr_addr),
        .onehot (we_raw)
    );

    rf_write_decoder #(.DEPTH(DEPTH), .AW(AW)) u_alloc_dec (
        .en     (alloc_valid),
        .addr   (alloc_addr),
        .onehot (al_raw)
    );

    assign we_vec = we_raw & LIVE_MASK;
    assign al_vec = al_raw & LIVE_MASK;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= INIT_VALUE;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we_vec[i]) begin
                    regs[i] <= wr_data;
                end
            end
            // Alloc is applied after the write-back clear so a same-cycle alloc leaves the bit set.
            busy <= (busy & ~we_vec) | al_vec;
        end
    end

    assign busy_vec = busy;

    // Read ports: a masked one-hot select makes the zero register and out-of-range
    // addresses read as 0 / ready without indexing past the array.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [DEPTH-1:0] sel;
        logic [WIDTH-1:0] dat;
        logic             rdy;

        assign addr = (p == 0) ? rd_addr_a : rd_addr_b;

        always_comb begin
            sel = '0;
            dat = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if ((addr == AW'(i)) && LIVE_MASK[i]) begin
                    sel[i] = 1'b1;
                    dat    = regs[i];
                end
            end
            rdy = ~|(sel & busy);
`ifdef REGFILE_BYPASS_EN
            if (|(sel & we_vec)) begin
                dat = wr_data;
                rdy = ~|(sel & al_vec);
            end
`endif
        end
    end

    assign rd_data_a  = g_rd[0].dat;
    assign rd_ready_a = g_rd[0].rdy;
    assign rd_data_b  = g_rd[1].dat;
    assign rd_ready_b = g_rd[1].rdy;

endmodule

// File: tb/tb_mips_reg_file_sb.sv
// Self-checking bench for mips_reg_file_sb (DEPTH=24, INIT_VALUE=5, ZERO_REG=1).
// Latency: n/a.
// Backpressure: n/a.
module tb_mips_reg_file_sb;

    localparam int          W    = 32;
    localparam int          D    = 24;
    localparam int          AW   = 5;
    localparam logic [31:0] INIT = 32'd5;

    logic          clk = 1'b0;
    logic          reset;
    logic          reg_write;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          alloc_valid;
    logic [AW-1:0] alloc_addr;
    logic [AW-1:0] rd_addr_a;
    logic [W-1:0]  rd_data_a;
    logic          rd_ready_a;
    logic [AW-1:0] rd_addr_b;
    logic [W-1:0]  rd_data_b;
    logic          rd_ready_b;
    logic [D-1:0]  busy_vec;

    always #5 clk = ~clk;

    mips_reg_file_sb #(
        .WIDTH      (W),
        .DEPTH      (D),
        .INIT_VALUE (INIT),
        .ZERO_REG   (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .reg_write   (reg_write),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .rd_addr_a   (rd_addr_a),
        .rd_data_a   (rd_data_a),
        .rd_ready_a  (rd_ready_a),
        .rd_addr_b   (rd_addr_b),
        .rd_data_b   (rd_data_b),
        .rd_ready_b  (rd_ready_b),
        .busy_vec    (busy_vec)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: architectural register contents and pending flags.
    logic [W-1:0] m_reg  [D];
    bit           m_busy [D];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic bit addr_ok(input logic [AW-1:0] a);
        return (a != 5'd0) && (int'(a) < D);
    endfunction

    task automatic model_read(input logic [AW-1:0] a, output logic [W-1:0] d, output logic r);
        d = '0;
        r = 1'b1;
        if (addr_ok(a)) begin
            d = m_reg[a];
            r = !m_busy[a];
`ifdef REGFILE_BYPASS_EN
            if (reg_write && wr_addr == a) begin
                d = wr_data;
                r = !(alloc_valid && alloc_addr == a);
            end
`endif
        end
    endtask

    function automatic logic [D-1:0] model_busy();
        logic [D-1:0] v = '0;
        for (int i = 0; i < D; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_edge();
        if (!reset) begin
            for (int i = 0; i < D; i++) begin
                m_reg[i]  = INIT;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (reg_write && addr_ok(wr_addr)) begin
                m_reg[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (alloc_valid && addr_ok(alloc_addr)) m_busy[alloc_addr] = 1'b1;
        end
    endtask

    task automatic drive(input logic rs, input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic av, input logic [AW-1:0] aa,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        reset       = rs;
        reg_write   = we;
        wr_addr     = wa;
        wr_data     = wd;
        alloc_valid = av;
        alloc_addr  = aa;
        rd_addr_a   = ra;
        rd_addr_b   = rb;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_edge();
    endtask

    task automatic check_ports(input string tag, input logic [W-1:0] ea, input logic era,
                               input logic [W-1:0] eb, input logic erb);
        check({tag, ".data_a"},  64'(rd_data_a),  64'(ea));
        check({tag, ".ready_a"}, 64'(rd_ready_a), 64'(era));
        check({tag, ".data_b"},  64'(rd_data_b),  64'(eb));
        check({tag, ".ready_b"}, 64'(rd_ready_b), 64'(erb));
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [W-1:0]  wd;
        logic          av;
        logic [AW-1:0] aa;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [W-1:0]  ea;
        logic          era;
        logic [W-1:0]  eb;
        logic          erb;
        logic [D-1:0]  ebusy;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [W-1:0] xa, xb;
        logic         ya, yb;

        // Outputs are checked before the edge on which the row's write/alloc commits.
        tbl[0]  = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0,  5'd1,  5'd2,  32'd5,        1'b1, 32'd5,        1'b1, 24'h0};
        tbl[1]  = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  5'd3,  5'd0,  32'hDEADBEEF, 1'b1, 32'd0,        1'b1, 24'h0};
        tbl[2]  = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd7,  5'd0,  5'd3,  32'd0,        1'b1, 32'hDEADBEEF, 1'b1, 24'h0};
        tbl[3]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  5'd3,  5'd7,  32'hDEADBEEF, 1'b1, 32'd5,        1'b0, 24'h000080};
        tbl[4]  = '{1'b1, 5'd7,  32'd9,        1'b0, 5'd0,  5'd2,  5'd3,  32'd5,        1'b1, 32'hDEADBEEF, 1'b1, 24'h000080};
        tbl[5]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  5'd7,  5'd7,  32'd9,        1'b1, 32'd9,        1'b1, 24'h0};
        tbl[6]  = '{1'b1, 5'd30, 32'hFFFFFFFF, 1'b1, 5'd30, 5'd30, 5'd23, 32'd0,        1'b1, 32'd5,        1'b1, 24'h0};
        tbl[7]  = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd0,  5'd30, 5'd0,  32'd0,        1'b1, 32'd0,        1'b1, 24'h0};
        tbl[8]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  5'd0,  5'd23, 32'd0,        1'b1, 32'd5,        1'b1, 24'h0};
        tbl[9]  = '{1'b1, 5'd5,  32'd3,        1'b1, 5'd5,  5'd1,  5'd2,  32'd5,        1'b1, 32'd5,        1'b1, 24'h0};
        tbl[10] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  5'd5,  5'd5,  32'd3,        1'b0, 32'd3,        1'b0, 24'h000020};
        tbl[11] = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd5,  5'd5,  5'd4,  32'd3,        1'b0, 32'd5,        1'b1, 24'h000020};
        tbl[12] = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd6,  5'd5,  5'd6,  32'd3,        1'b0, 32'd5,        1'b1, 24'h000020};

        // Reset for two cycles while a write and an alloc are requested; reset must win.
        drive(1'b0, 1'b1, 5'd3, 32'd77, 1'b1, 5'd6, 5'd0, 5'd0);
        clock_edge();
        clock_edge();

        // Post-reset sweep of every in-range address on both ports.
        for (int a = 0; a < D; a++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(a), 5'(a));
            #1;
            check_ports($sformatf("reset_r%0d", a), (a == 0) ? 32'd0 : INIT, 1'b1,
                        (a == 0) ? 32'd0 : INIT, 1'b1);
            check("reset.busy_vec", 64'(busy_vec), 64'(0));
            clock_edge();
        end

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(1'b1, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].av, tbl[i].aa, tbl[i].ra, tbl[i].rb);
            #1;
            check_ports($sformatf("vec%0d", i), tbl[i].ea, tbl[i].era, tbl[i].eb, tbl[i].erb);
            check($sformatf("vec%0d.busy_vec", i), 64'(busy_vec), 64'(tbl[i].ebusy));
            clock_edge();
        end

        // r5 and r6 pending; reset with a same-cycle write and alloc clears everything.
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd5, 32'd77, 1'b1, 5'd4, 5'd5, 5'd6);
        #1;
        check("pre_reset.busy_vec", 64'(busy_vec), 64'(24'h000060));
        clock_edge();
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd4);
        #1;
        check_ports("post_reset", INIT, 1'b1, INIT, 1'b1);
        check("post_reset.busy_vec", 64'(busy_vec), 64'(0));
        clock_edge();

        // Read of the register being written in the same cycle.
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd4, 32'hAA, 1'b0, 5'd0, 5'd4, 5'd4);
        #1;
`ifdef REGFILE_BYPASS_EN
        check_ports("same_cycle_rw", 32'hAA, 1'b1, 32'hAA, 1'b1);
`else
        check_ports("same_cycle_rw", INIT, 1'b1, INIT, 1'b1);
`endif
        clock_edge();
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4);
        #1;
        check_ports("after_rw", 32'hAA, 1'b1, 32'hAA, 1'b1);
        clock_edge();

        // Same-cycle write and alloc to r8 while reading it.
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd8, 32'd11, 1'b1, 5'd8, 5'd8, 5'd9);
        #1;
`ifdef REGFILE_BYPASS_EN
        check_ports("rw_alloc", 32'd11, 1'b0, INIT, 1'b1);
`else
        check_ports("rw_alloc", INIT, 1'b1, INIT, 1'b1);
`endif
        clock_edge();
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd8, 5'd8);
        #1;
        check_ports("after_rw_alloc", 32'd11, 1'b0, 32'd11, 1'b0);
        check("after_rw_alloc.busy_vec", 64'(busy_vec), 64'(24'h000100));
        clock_edge();

        // Randomized traffic against the reference model; addresses biased toward a few hot registers.
        for (int c = 0; c < 600; c++) begin
            logic [AW-1:0] wa, aa, ra, rb;
            @(negedge clk);
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            aa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            drive(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), wa, $urandom,
                  1'($urandom_range(0, 1)), aa, ra, rb);
            #1;
            model_read(rd_addr_a, xa, ya);
            model_read(rd_addr_b, xb, yb);
            check_ports($sformatf("rand%0d", c), xa, ya, xb, yb);
            check($sformatf("rand%0d.busy_vec", c), 64'(busy_vec), 64'(model_busy()));
            clock_edge();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
